// File: rtl/matrix_pkg.sv
// Shared definitions for the 8x8 Game-of-Life core: board size, board type
// and the default glider seed.
package matrix_pkg;

  localparam int GRID_N = 8;

  typedef logic [GRID_N-1:0][GRID_N-1:0] grid_t;

  // Glider in rows 0-2: row 0 = col 1, row 1 = col 2, row 2 = cols 0..2.
  localparam grid_t GLIDER_SEED = 64'h0000_0000_0007_0402;

endpackage

// File: rtl/matrix_life_cell.sv
// One Game-of-Life cell: counts its eight neighbours, applies B3/S23 and
// holds its own state. Reset loads the cell's seed value.
module life_cell (
  input  logic       clk,
  input  logic       _rst,
  input  logic       init,
  input  logic [7:0] nbr,
  output logic       alive
);

  logic [3:0] count;
  logic       alive_next;

  // Neighbour popcount (0..8 fits in 4 bits) and the birth/survival rule.
  always_comb begin
    count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'd0, nbr[i]};
    end
    alive_next = (count == 4'd3) || ((count == 4'd2) && alive);
  end

  // Cell state; reset reloads the seed bit regardless of clk.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      alive <= init;
    end else begin
      alive <= alive_next;
    end
  end

endmodule

// File: rtl/matrix.sv
// 8x8 toroidal Game-of-Life board. Advances one generation per clk edge;
// every cell reads the pre-edge board, so all 64 update in lockstep.
module matrix
  import matrix_pkg::*;
#(
  parameter grid_t INIT_GRID = GLIDER_SEED
) (
  input  logic                           clk,
  input  logic                           _rst,
  output logic [GRID_N-1:0][GRID_N-1:0]  grid
);

  for (genvar r = 0; r < GRID_N; r++) begin : g_row
    for (genvar c = 0; c < GRID_N; c++) begin : g_col
      // Wrap-around indices: row 0's upper neighbour is row 7, etc.
      localparam int RU = (r + GRID_N - 1) % GRID_N;
      localparam int RD = (r + 1) % GRID_N;
      localparam int CL = (c + GRID_N - 1) % GRID_N;
      localparam int CR = (c + 1) % GRID_N;

      logic [7:0] nbr;

      assign nbr = {grid[RU][CL], grid[RU][c], grid[RU][CR],
                    grid[r][CL],               grid[r][CR],
                    grid[RD][CL], grid[RD][c], grid[RD][CR]};

      life_cell u_cell (
        .clk   (clk),
        ._rst  (_rst),
        .init  (INIT_GRID[r][c]),
        .nbr   (nbr),
        .alive (grid[r][c])
      );
    end
  end

endmodule

// File: tb/tb_matrix.sv
// Bench for matrix: several boards with different seeds run side by side
// against a direct array model of Conway's rules on an 8x8 torus.
module tb_matrix;
  import matrix_pkg::*;

  localparam int NI = 6;

  localparam grid_t SEED_DEF  = 64'h0000_0000_0007_0402;
  localparam grid_t SEED_BLK  = 64'h0000_0000_1C00_0000;
  localparam grid_t SEED_COR  = 64'h8100_0000_0000_0081;
  localparam grid_t SEED_ZERO = 64'h0000_0000_0000_0000;
  localparam grid_t SEED_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam grid_t SEED_RND  = 64'h3C5A_9E17_64B2_D80F;

  logic  clk;
  logic  _rst;
  grid_t obs   [NI];
  grid_t model [NI];
  grid_t seeds [NI];
  int    compared   = 0;
  int    mismatched = 0;

  matrix #(.INIT_GRID(SEED_DEF))  u_def  (.clk(clk), ._rst(_rst), .grid(obs[0]));
  matrix #(.INIT_GRID(SEED_BLK))  u_blk  (.clk(clk), ._rst(_rst), .grid(obs[1]));
  matrix #(.INIT_GRID(SEED_COR))  u_cor  (.clk(clk), ._rst(_rst), .grid(obs[2]));
  matrix #(.INIT_GRID(SEED_ZERO)) u_zero (.clk(clk), ._rst(_rst), .grid(obs[3]));
  matrix #(.INIT_GRID(SEED_ONES)) u_ones (.clk(clk), ._rst(_rst), .grid(obs[4]));
  matrix #(.INIT_GRID(SEED_RND))  u_rnd  (.clk(clk), ._rst(_rst), .grid(obs[5]));

  // Reference generation step: count the 8 wrapped neighbours of each cell.
  function automatic grid_t life_step(input grid_t g);
    grid_t n;
    int    cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              cnt = cnt + int'(g[(r + dr + 8) % 8][(c + dc + 8) % 8]);
            end
          end
        end
        n[r][c] = (cnt == 3) || (cnt == 2 && g[r][c] == 1'b1);
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input grid_t o, input grid_t e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s[%0d]", tag, i), obs[i], model[i]);
    end
  endtask

  // One rising edge; outputs are sampled on the following low phase.
  task automatic edge_step();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
    for (int i = 0; i < NI; i++) begin
      model[i] = life_step(model[i]);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NI; i++) begin
      model[i] = seeds[i];
    end
  endtask

  // Drop reset in the low phase, confirm reload, then clock while held.
  task automatic mid_reset(input string tag, input int hold_edges);
    #($urandom_range(1, 3));
    _rst = 1'b0;
    #1;
    reset_model();
    check_all({tag, "_load"});
    for (int k = 0; k < hold_edges; k++) begin
      #5 clk = 1'b1;
      #5 clk = 1'b0;
    end
    check_all({tag, "_hold"});
    _rst = 1'b1;
    #2;
  endtask

  initial begin
    int n;
    seeds[0] = SEED_DEF;
    seeds[1] = SEED_BLK;
    seeds[2] = SEED_COR;
    seeds[3] = SEED_ZERO;
    seeds[4] = SEED_ONES;
    seeds[5] = SEED_RND;
    clk  = 1'b0;
    _rst = 1'b1;

    #3 _rst = 1'b0;
    #2;
    reset_model();
    check("seed_default", obs[0], 64'h0000_0000_0007_0402);
    check_all("reset");
    _rst = 1'b1;
    #5;

    edge_step();
    check("blinker_g1", obs[1], 64'h0000_0008_0808_0000);
    check("ones_g1", obs[4], 64'h0);
    check_all("g1");
    edge_step();
    check("blinker_g2", obs[1], 64'h0000_0000_1C00_0000);
    check_all("g2");
    edge_step();
    check("zero_g3", obs[3], 64'h0);
    check_all("g3");
    edge_step();
    check("glider_g4", obs[0], 64'h0000_0000_0E08_0400);
    check_all("g4");
    edge_step();
    check("corners_g5", obs[2], 64'h8100_0000_0000_0081);
    check_all("g5");
    for (int g = 6; g <= 32; g++) begin
      edge_step();
      check_all($sformatf("g%0d", g));
    end
    check("glider_g32", obs[0], 64'h0000_0000_0007_0402);

    // Restart from seed, run 3 generations, then reset between edges.
    mid_reset("restart", 0);
    for (int k = 0; k < 3; k++) begin
      edge_step();
    end
    check_all("pre_reset_g3");
    mid_reset("mid_run", 2);
    check("mid_run_seed", obs[0], 64'h0000_0000_0007_0402);

    // Randomised run lengths with resets dropped at random points.
    for (int rnd = 0; rnd < 4; rnd++) begin
      n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) begin
        edge_step();
        check_all($sformatf("rnd%0d_g%0d", rnd, k + 1));
      end
      mid_reset($sformatf("rnd%0d", rnd), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
